lpddr2_avalon_bridge: RTL and testbench

- Sits directly downstream of the CPU memory master's LPDDR2 port.
- Converts its level-style read_req/write_req, word address and write data into single-beat Avalon-MM transactions for the LPDDR2 hard controller.
- Returns read data through a one-entry read cache that holds the last line read. Drives stall back to the CPU clock-enable logic while a transaction is in flight.

---
 rtl/lpddr2_avalon_bridge_if.sv | 27 ++
 rtl/lpddr2_avalon_bridge.sv | 133 +++++++++++++
 tb/tb_lpddr2_avalon_bridge.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpddr2_avalon_bridge_if.sv
// Avalon-MM command/response bundle between the LPDDR2 bridge (master)
// and the LPDDR2 hard controller (slave), including calibration status.
interface lpddr2_avalon_bridge_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   avl_addr;
    logic [DATA_W-1:0]   avl_wdata;
    logic [DATA_W/8-1:0] avl_be;
    logic                avl_read;
    logic                avl_write;
    logic                avl_burstbegin;
    logic                avl_ready;
    logic [DATA_W-1:0]   avl_rdata;
    logic                avl_rdata_valid;
    logic                local_init_done;

    modport master (
        output avl_addr, avl_wdata, avl_be, avl_read, avl_write, avl_burstbegin,
        input  avl_ready, avl_rdata, avl_rdata_valid, local_init_done
    );

    modport slave (
        input  avl_addr, avl_wdata, avl_be, avl_read, avl_write, avl_burstbegin,
        output avl_ready, avl_rdata, avl_rdata_valid, local_init_done
    );
endinterface

// File: rtl/lpddr2_avalon_bridge.sv
// Turns the CPU's level read/write requests into single-beat Avalon-MM commands,
// with a one-line read cache and a stall back to the CPU clock-enable logic.
module lpddr2_avalon_bridge #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     write_data,
    input  logic                  read_req,
    input  logic                  write_req,
    output logic [DATA_W-1:0]     read_data,
    output logic                  stall,
    output logic                  err,
    lpddr2_avalon_bridge_if.master avl
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {INIT, IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE} state_t;

    state_t             state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic               read_reg;
    logic               write_reg;
    logic               burst_reg;
    logic               err_reg;
    logic               cache_valid_reg;
    logic [ADDR_W-1:0]  cache_tag_reg;
    logic [DATA_W-1:0]  cache_data_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               hit;

    assign hit = cache_valid_reg && (cache_tag_reg == address);

    always_comb begin
        stall = 1'b0;
        case (state_reg)
            INIT:     stall = read_req | write_req;
            IDLE:     stall = write_req | (read_req & ~hit);
            WR_ISSUE: stall = 1'b1;
            RD_ISSUE: stall = 1'b1;
            RD_WAIT:  stall = 1'b1;
            DONE:     stall = 1'b0;
            default:  stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= INIT;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            read_reg        <= 1'b0;
            write_reg       <= 1'b0;
            burst_reg       <= 1'b0;
            err_reg         <= 1'b0;
            cache_valid_reg <= 1'b0;
            cache_tag_reg   <= '0;
            cache_data_reg  <= '0;
            cnt_reg         <= '0;
        end else begin
            // burstbegin is a single-cycle pulse marking the first command cycle
            burst_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    if (avl.local_init_done) state_reg <= IDLE;
                end
                IDLE: begin
                    if (write_req) begin
                        addr_reg  <= address;
                        wdata_reg <= write_data;
                        write_reg <= 1'b1;
                        burst_reg <= 1'b1;
                        state_reg <= WR_ISSUE;
                    end else if (read_req && !hit) begin
                        addr_reg  <= address;
                        read_reg  <= 1'b1;
                        burst_reg <= 1'b1;
                        state_reg <= RD_ISSUE;
                    end
                end
                WR_ISSUE: begin
                    if (avl.avl_ready) begin
                        write_reg <= 1'b0;
                        // write-through keeps a cached line coherent with memory
                        if (cache_tag_reg == addr_reg) cache_data_reg <= wdata_reg;
                        state_reg <= DONE;
                    end
                end
                RD_ISSUE: begin
                    if (avl.avl_ready) begin
                        read_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (avl.avl_rdata_valid) begin
                        cache_tag_reg   <= addr_reg;
                        cache_data_reg  <= avl.avl_rdata;
                        cache_valid_reg <= 1'b1;
                        state_reg       <= IDLE;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        // abandon the read: no retry, cache dropped, error is sticky
                        err_reg         <= 1'b1;
                        cache_valid_reg <= 1'b0;
                        state_reg       <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= INIT;
                end
            endcase
        end
    end

    assign read_data          = cache_data_reg;
    assign err                = err_reg;
    assign avl.avl_addr       = addr_reg;
    assign avl.avl_wdata      = wdata_reg;
    assign avl.avl_be         = '1;
    assign avl.avl_read       = read_reg;
    assign avl.avl_write      = write_reg;
    assign avl.avl_burstbegin = burst_reg;
endmodule

// File: tb/tb_lpddr2_avalon_bridge.sv
// Directed bench for lpddr2_avalon_bridge: reset/init, read miss and hit,
// write-through with backpressure, request priority, read timeout, mid-write reset.
module tb_lpddr2_avalon_bridge;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              read_req;
    logic              write_req;
    logic [DATA_W-1:0] read_data;
    logic              stall;
    logic              err;

    int errors = 0;
    int checks = 0;

    lpddr2_avalon_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) avl_bus ();

    lpddr2_avalon_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .write_data (write_data),
        .read_req   (read_req),
        .write_req  (write_req),
        .read_data  (read_data),
        .stall      (stall),
        .err        (err),
        .avl        (avl_bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        address    = 27'h100;
        write_data = '0;
        read_req   = 1'b1;
        write_req  = 1'b0;
        avl_bus.local_init_done = 1'b0;
        avl_bus.avl_ready       = 1'b0;
        avl_bus.avl_rdata       = '0;
        avl_bus.avl_rdata_valid = 1'b0;
        #2;
        chk("reset_stall", 64'(stall), 64'd1);
        chk("reset_avl_read", 64'(avl_bus.avl_read), 64'd0);
        chk("reset_avl_write", 64'(avl_bus.avl_write), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_read_data", 64'(read_data), 64'd0);
        chk("reset_avl_addr", 64'(avl_bus.avl_addr), 64'd0);
        chk("reset_burst", 64'(avl_bus.avl_burstbegin), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_stall", 64'(stall), 64'd1);
        chk("init_avl_read", 64'(avl_bus.avl_read), 64'd0);

        // calibration completes; read to 0x100 misses
        tick();
        avl_bus.local_init_done = 1'b1;
        avl_bus.avl_ready = 1'b1;
        @(negedge clk);
        chk("init_hold_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("idle_miss_stall", 64'(stall), 64'd1);
        chk("idle_miss_no_read", 64'(avl_bus.avl_read), 64'd0);
        tick();
        @(negedge clk);
        chk("rd_issue_read", 64'(avl_bus.avl_read), 64'd1);
        chk("rd_issue_burst", 64'(avl_bus.avl_burstbegin), 64'd1);
        chk("rd_issue_addr", 64'(avl_bus.avl_addr), 64'h100);
        chk("rd_issue_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("rd_wait1_stall", 64'(stall), 64'd1);
        chk("rd_wait1_read", 64'(avl_bus.avl_read), 64'd0);
        chk("rd_wait1_burst", 64'(avl_bus.avl_burstbegin), 64'd0);
        tick();
        avl_bus.avl_rdata_valid = 1'b1;
        avl_bus.avl_rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rd_wait2_stall", 64'(stall), 64'd1);
        chk("rd_wait2_old_data", 64'(read_data), 64'd0);
        tick();
        avl_bus.avl_rdata_valid = 1'b0;
        @(negedge clk);
        chk("rd_hit_stall", 64'(stall), 64'd0);
        chk("rd_hit_data", 64'(read_data), 64'hCAFEF00D);
        chk("rd_hit_no_read", 64'(avl_bus.avl_read), 64'd0);
        tick();
        @(negedge clk);
        chk("rd_hit2_no_read", 64'(avl_bus.avl_read), 64'd0);
        chk("rd_hit2_stall", 64'(stall), 64'd0);
        $display("txn read  addr=%h data=%h", 27'h100, read_data);

        // write 0x100 with three cycles of backpressure; init_done drop is ignored
        tick();
        read_req = 1'b0;
        write_req = 1'b1;
        address = 27'h100;
        write_data = 32'h12345678;
        avl_bus.avl_ready = 1'b0;
        avl_bus.local_init_done = 1'b0;
        @(negedge clk);
        chk("wr_idle_stall", 64'(stall), 64'd1);
        chk("wr_idle_no_write", 64'(avl_bus.avl_write), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) avl_bus.avl_ready = 1'b1;
            @(negedge clk);
            chk("wr_issue_write", 64'(avl_bus.avl_write), 64'd1);
            chk("wr_issue_burst", 64'(avl_bus.avl_burstbegin), (i == 0) ? 64'd1 : 64'd0);
            chk("wr_issue_addr", 64'(avl_bus.avl_addr), 64'h100);
            chk("wr_issue_wdata", 64'(avl_bus.avl_wdata), 64'h12345678);
            chk("wr_issue_be", 64'(avl_bus.avl_be), 64'hF);
            chk("wr_issue_stall", 64'(stall), 64'd1);
        end
        chk("wr_issue_cache_old", 64'(read_data), 64'hCAFEF00D);
        tick();
        write_req = 1'b0;
        read_req = 1'b1;
        avl_bus.avl_ready = 1'b0;
        @(negedge clk);
        chk("wr_done_stall", 64'(stall), 64'd0);
        chk("wr_done_write", 64'(avl_bus.avl_write), 64'd0);
        tick();
        @(negedge clk);
        chk("wr_thru_hit_stall", 64'(stall), 64'd0);
        chk("wr_thru_hit_data", 64'(read_data), 64'h12345678);
        chk("wr_thru_no_read", 64'(avl_bus.avl_read), 64'd0);
        $display("txn write addr=%h data=%h", 27'h100, 32'h12345678);

        // simultaneous read and write: write wins, cache untouched (tag differs)
        tick();
        write_req = 1'b1;
        address = 27'h200;
        write_data = 32'hA5A5A5A5;
        avl_bus.avl_ready = 1'b1;
        @(negedge clk);
        chk("both_idle_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("both_write", 64'(avl_bus.avl_write), 64'd1);
        chk("both_no_read", 64'(avl_bus.avl_read), 64'd0);
        chk("both_addr", 64'(avl_bus.avl_addr), 64'h200);
        chk("both_wdata", 64'(avl_bus.avl_wdata), 64'hA5A5A5A5);
        tick();
        read_req = 1'b0;
        write_req = 1'b0;
        @(negedge clk);
        chk("both_done_stall", 64'(stall), 64'd0);
        chk("both_done_read", 64'(avl_bus.avl_read), 64'd0);
        tick();
        read_req = 1'b1;
        address = 27'h100;
        @(negedge clk);
        chk("both_after_stall", 64'(stall), 64'd0);
        chk("both_after_data", 64'(read_data), 64'h12345678);
        $display("txn write addr=%h data=%h (read also requested)", 27'h200, 32'hA5A5A5A5);

        // stray rdata_valid in IDLE must not touch the cache
        tick();
        read_req = 1'b0;
        avl_bus.avl_rdata_valid = 1'b1;
        avl_bus.avl_rdata = 32'hDEADBEEF;
        tick();
        avl_bus.avl_rdata_valid = 1'b0;
        @(negedge clk);
        chk("stray_valid_data", 64'(read_data), 64'h12345678);

        // read timeout: 8 RD_WAIT cycles then err, cache invalidated
        tick();
        read_req = 1'b1;
        address = 27'h300;
        @(negedge clk);
        chk("to_idle_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("to_issue_read", 64'(avl_bus.avl_read), 64'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) read_req = 1'b0;
            @(negedge clk);
            chk("to_wait_stall", 64'(stall), 64'd1);
            chk("to_wait_err", 64'(err), 64'd0);
        end
        tick();
        @(negedge clk);
        chk("to_err", 64'(err), 64'd1);
        chk("to_stall", 64'(stall), 64'd0);
        $display("txn read  addr=%h timed out err=%0d", 27'h300, err);
        tick();
        read_req = 1'b1;
        address = 27'h100;
        @(negedge clk);
        chk("to_inval_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("to_reissue_read", 64'(avl_bus.avl_read), 64'd1);
        chk("to_reissue_addr", 64'(avl_bus.avl_addr), 64'h100);
        tick();
        avl_bus.avl_rdata_valid = 1'b1;
        avl_bus.avl_rdata = 32'h55AA55AA;
        @(negedge clk);
        chk("to_refill_stall", 64'(stall), 64'd1);
        tick();
        avl_bus.avl_rdata_valid = 1'b0;
        @(negedge clk);
        chk("to_refill_hit", 64'(stall), 64'd0);
        chk("to_refill_data", 64'(read_data), 64'h55AA55AA);
        chk("to_err_sticky", 64'(err), 64'd1);
        $display("txn read  addr=%h data=%h", 27'h100, read_data);

        // asynchronous reset in the middle of a write
        tick();
        read_req = 1'b0;
        write_req = 1'b1;
        address = 27'h400;
        write_data = 32'h0F0F0F0F;
        avl_bus.avl_ready = 1'b0;
        @(negedge clk);
        chk("rst_wr_idle_stall", 64'(stall), 64'd1);
        tick();
        @(negedge clk);
        chk("rst_wr_issue", 64'(avl_bus.avl_write), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_write", 64'(avl_bus.avl_write), 64'd0);
        chk("rst_async_burst", 64'(avl_bus.avl_burstbegin), 64'd0);
        chk("rst_async_err", 64'(err), 64'd0);
        chk("rst_async_addr", 64'(avl_bus.avl_addr), 64'd0);
        chk("rst_async_data", 64'(read_data), 64'd0);
        chk("rst_init_stall", 64'(stall), 64'd1);
        tick();
        write_req = 1'b0;
        @(negedge clk);
        chk("rst_hold_write", 64'(avl_bus.avl_write), 64'd0);
        chk("rst_init_no_req", 64'(stall), 64'd0);
        $display("txn write addr=%h aborted by reset", 27'h400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
